// File: rtl/mux_nto1_stream.sv
// N-to-1 valid/ready stream mux. Channel selection is fixed or round-robin.
// The output is a single-entry register, and a counter tracks output handshakes.
module mux_nto1_stream #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [(WIDTH<<SEL_W)-1:0] in_data,
  input  logic [(1<<SEL_W)-1:0]     in_valid,
  output logic [(1<<SEL_W)-1:0]     in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_en,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan,
  output logic [15:0]               xfer_count
);
  localparam int N = 1 << SEL_W;

  logic [SEL_W-1:0] r_ptr;
  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic [SEL_W-1:0] r_outChan;
  logic [15:0]      r_xferCount;

  logic             w_rrFound;
  logic [SEL_W-1:0] w_rrChan;
  logic             w_load;
  logic [SEL_W-1:0] w_chan;
  logic             w_hasGrant;
  logic [N-1:0]     w_ready;
  logic             w_xfer;
  logic             w_drain;
  logic [WIDTH-1:0] w_chanData;

  // Find the first valid channel at or after the pointer. The loop walks from
  // the far end, so the nearest offset is the last value written and wins.
  always_comb begin
    w_rrFound = 1'b0;
    w_rrChan  = r_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[r_ptr + SEL_W'(k)]) begin
        w_rrFound = 1'b1;
        w_rrChan  = r_ptr + SEL_W'(k);
      end
    end
  end

  always_comb begin
    w_load     = !r_outValid || out_ready;
    w_chan     = rr_en ? w_rrChan : sel;
    w_hasGrant = rr_en ? w_rrFound : 1'b1;
    w_ready    = '0;
    if (rst_n && w_hasGrant && w_load) begin
      w_ready[w_chan] = 1'b1;
    end
    w_xfer     = in_valid[w_chan] && w_ready[w_chan];
    w_drain    = r_outValid && out_ready;
    w_chanData = in_data[w_chan*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outChan  <= '0;
    end else if (w_xfer) begin
      r_outValid <= 1'b1;
      r_outData  <= w_chanData;
      r_outChan  <= w_chan;
    end else if (w_load) begin
      r_outValid <= 1'b0;
    end
  end

  // Only round-robin grants advance the pointer; fixed-mode traffic leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer && rr_en) begin
      r_ptr <= w_chan + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xferCount <= '0;
    end else if (w_drain) begin
      r_xferCount <= r_xferCount + 16'd1;
    end
  end

  assign in_ready   = w_ready;
  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
  assign out_chan   = r_outChan;
  assign xfer_count = r_xferCount;

endmodule
